// File: rtl/exmem_pkg.sv
// Shared EX/MEM types: the control bundle, the width constant and a macro that
// builds the payload struct for any DATA_W/REG_ADDR_W.
`ifndef EXMEM_PKG_SV
`define EXMEM_PKG_SV

package exmem_pkg;

  localparam int EXMEM_CTRL_W = 5;

  typedef struct packed {
    logic wbs;
    logic mm;
    logic wm;
    logic ni;
    logic wme;
  } exmem_ctrl_t;

  function automatic int exmem_payload_w(input int data_w, input int reg_addr_w);
    return EXMEM_CTRL_W + 2 * data_w + reg_addr_w;
  endfunction

endpackage

// Packages cannot take parameters, so the width-dependent payload is a macro.
`define EXMEM_PAYLOAD_T(dw, aw) \
  struct packed { \
    exmem_pkg::exmem_ctrl_t ctrl; \
    logic [(dw)-1:0] alu_result; \
    logic [(dw)-1:0] mem_data; \
    logic [(aw)-1:0] reg_dest; \
  }

`endif

// File: rtl/execute_memory_stage_if.sv
// EX/MEM boundary bus: execute-side inputs, memory-side outputs and the handshakes.
// master = surrounding pipeline, slave = the stage register.
interface execute_memory_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  wbs_in, mm_in, wm_in, ni_in, wme_in;
  logic [DATA_W-1:0]     alu_result_in;
  logic [DATA_W-1:0]     mem_data_in;
  logic [REG_ADDR_W-1:0] reg_dest_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  wbs_out, mm_out, wm_out, ni_out, wme_out;
  logic [DATA_W-1:0]     alu_result_out;
  logic [DATA_W-1:0]     mem_data_out;
  logic [REG_ADDR_W-1:0] reg_dest_out;

  modport master (
    output in_valid, flush, wbs_in, mm_in, wm_in, ni_in, wme_in,
           alu_result_in, mem_data_in, reg_dest_in, out_ready,
    input  in_ready, out_valid, wbs_out, mm_out, wm_out, ni_out, wme_out,
           alu_result_out, mem_data_out, reg_dest_out
  );

  modport slave (
    input  in_valid, flush, wbs_in, mm_in, wm_in, ni_in, wme_in,
           alu_result_in, mem_data_in, reg_dest_in, out_ready,
    output in_ready, out_valid, wbs_out, mm_out, wm_out, ni_out, wme_out,
           alu_result_out, mem_data_out, reg_dest_out
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register on a packed vector with synchronous flush.
// Optional 1-entry skid buffer when EXMEM_SKID_EN is defined.
module pipe_skid_reg #(
  parameter int W               = 8,
  parameter bit RESET_DATA_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         main_free;

  // Main slot can take new content if empty or being drained this edge.
  assign main_free = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef EXMEM_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_xfer;

  // Registered ready: no combinational path from out_ready.
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      if (RESET_DATA_ZERO) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_xfer;
        if (in_xfer) main_data <= in_data;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = main_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      if (RESET_DATA_ZERO) main_data <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= in_valid;
      if (in_valid) main_data <= in_data;
    end
  end
`endif

endmodule

// File: rtl/execute_memory_stage.sv
// EX/MEM pipeline boundary: packs the execute result into a pipe_skid_reg and gates
// the control outputs with out_valid. Skid buffering is enabled by EXMEM_SKID_EN.
module execute_memory_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int REG_ADDR_W      = 5,
  parameter bit RESET_CTRL_ZERO = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  execute_memory_stage_if.slave bus
);

  typedef `EXMEM_PAYLOAD_T(DATA_W, REG_ADDR_W) exmem_payload_t;

  localparam int PAYLOAD_W = exmem_payload_w(DATA_W, REG_ADDR_W);

  exmem_payload_t pl_in;
  exmem_payload_t pl_out;
  logic           valid_q;

  assign pl_in.ctrl.wbs   = bus.wbs_in;
  assign pl_in.ctrl.mm    = bus.mm_in;
  assign pl_in.ctrl.wm    = bus.wm_in;
  assign pl_in.ctrl.ni    = bus.ni_in;
  assign pl_in.ctrl.wme   = bus.wme_in;
  assign pl_in.alu_result = bus.alu_result_in;
  assign pl_in.mem_data   = bus.mem_data_in;
  assign pl_in.reg_dest   = bus.reg_dest_in;

  pipe_skid_reg #(
    .W               (PAYLOAD_W),
    .RESET_DATA_ZERO (RESET_CTRL_ZERO)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pl_in),
    .out_valid (valid_q),
    .out_ready (bus.out_ready),
    .out_data  (pl_out)
  );

  // A bubble must never write memory or the register file.
  assign bus.out_valid      = valid_q;
  assign bus.wbs_out        = pl_out.ctrl.wbs & valid_q;
  assign bus.mm_out         = pl_out.ctrl.mm  & valid_q;
  assign bus.wm_out         = pl_out.ctrl.wm  & valid_q;
  assign bus.ni_out         = pl_out.ctrl.ni  & valid_q;
  assign bus.wme_out        = pl_out.ctrl.wme & valid_q;
  assign bus.alu_result_out = pl_out.alu_result;
  assign bus.mem_data_out   = pl_out.mem_data;
  assign bus.reg_dest_out   = pl_out.reg_dest;

endmodule

// File: tb/tb_execute_memory_stage.sv
// Directed + random bench for execute_memory_stage against a queue-based occupancy model.
module tb_execute_memory_stage;

  localparam int DW = 32;
  localparam int AW = 6;
`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [4:0]    ctrl;  // wbs, mm, wm, ni, wme
    logic [DW-1:0] alu;
    logic [DW-1:0] md;
    logic [AW-1:0] rd;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_memory_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  execute_memory_stage #(
    .DATA_W(DW), .REG_ADDR_W(AW), .RESET_CTRL_ZERO(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t q[$];
  item_t last;
  int    total = 0;
  int    bad = 0;
  int    xfers = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [4:0] c, input logic [DW-1:0] a,
                               input logic [DW-1:0] m, input logic [AW-1:0] r);
    item_t it;
    it.ctrl = c; it.alu = a; it.md = m; it.rd = r;
    return it;
  endfunction

  function automatic item_t rnd_item();
    return mk(5'($urandom), $urandom, $urandom, AW'($urandom));
  endfunction

  task automatic drive(input bit v, input bit ordy, input bit fl, input item_t it);
    bus.in_valid      = v;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    bus.wbs_in        = it.ctrl[4];
    bus.mm_in         = it.ctrl[3];
    bus.wm_in         = it.ctrl[2];
    bus.ni_in         = it.ctrl[1];
    bus.wme_in        = it.ctrl[0];
    bus.alu_result_in = it.alu;
    bus.mem_data_in   = it.md;
    bus.reg_dest_in   = it.rd;
  endtask

  // One clock: check ready, advance model at posedge, check outputs at negedge.
  task automatic cycle(output bit acc);
    bit    exp_rdy, out_x, exp_v;
    item_t it;
    #1;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (bus.out_ready || q.size() == 0);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc   = bus.in_valid && exp_rdy;
    out_x = (q.size() > 0) && bus.out_ready;
    it    = mk({bus.wbs_in, bus.mm_in, bus.wm_in, bus.ni_in, bus.wme_in},
               bus.alu_result_in, bus.mem_data_in, bus.reg_dest_in);
    @(posedge clk);
    if (bus.flush) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (out_x) begin
        void'(q.pop_front());
        xfers++;
      end
      if (acc) q.push_back(it);
    end
    if (q.size() > 0) last = q[0];
    @(negedge clk);
    exp_v = q.size() > 0;
    chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
    chk("ctrl_out", 64'({bus.wbs_out, bus.mm_out, bus.wm_out, bus.ni_out, bus.wme_out}),
        64'(last.ctrl & {5{exp_v}}));
    chk("alu_result_out", 64'(bus.alu_result_out), 64'(last.alu));
    chk("mem_data_out", 64'(bus.mem_data_out), 64'(last.md));
    chk("reg_dest_out", 64'(bus.reg_dest_out), 64'(last.rd));
  endtask

  initial begin
    bit    acc, pending;
    int    x0;
    item_t idle;
    idle = mk(5'b0, '0, '0, '0);
    last = idle;
    drive(0, 1, 0, idle);

    // reset values
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_ctrl", 64'({bus.wbs_out, bus.mm_out, bus.wm_out, bus.ni_out, bus.wme_out}), 64'd0);
    chk("rst_alu_zero", 64'(bus.alu_result_out), 64'd0);
    chk("rst_mem_zero", 64'(bus.mem_data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming 1..8
    x0 = xfers;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, mk(5'b10001, DW'(i), DW'(i * 3), AW'(i)));
      cycle(acc);
    end
    drive(0, 1, 0, idle);
    cycle(acc);
    chk("stream_xfers", 64'(xfers - x0), 64'd8);

    // stall with 0xBEEF, second item 0x1234 behind it
    drive(1, 1, 0, mk(5'b00100, 32'hBEEF, 32'h11, 6'd3));
    cycle(acc);
    pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pending, 0, 0, mk(5'b00010, 32'h1234, 32'h22, 6'd4));
      cycle(acc);
      if (acc) pending = 1'b0;
      chk("stall_alu", 64'(bus.alu_result_out), 64'hBEEF);
      chk("stall_wm", 64'(bus.wm_out), 64'd1);
    end
    chk("stall_skid_took", 64'(pending), (CAP == 2) ? 64'd0 : 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(pending, 1, 0, mk(5'b00010, 32'h1234, 32'h22, 6'd4));
      cycle(acc);
      if (acc) pending = 1'b0;
    end

    // flush with main (and skid) full
    drive(1, 0, 0, mk(5'b00001, 32'hA1, 32'h1, 6'd1));
    cycle(acc);
    drive(1, 0, 0, mk(5'b00001, 32'hA2, 32'h2, 6'd2));
    cycle(acc);
    drive(1, 1, 1, mk(5'b00001, 32'h5555, 32'h5, 6'd5));
    cycle(acc);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_wme", 64'(bus.wme_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, idle);
      cycle(acc);
      chk("flush_no_5555", 64'(bus.out_valid && bus.alu_result_out == 32'h5555), 64'd0);
    end

    // bubble gating
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, mk(5'b10100, 32'h77, 32'h77, 6'd7));
      cycle(acc);
      chk("bubble_wm", 64'(bus.wm_out), 64'd0);
      chk("bubble_wbs", 64'(bus.wbs_out), 64'd0);
    end

    // full-width copy
    drive(1, 1, 0, mk(5'b00100, 32'hFFFF_0001, 32'hA5A5_5A5A, 6'd63));
    cycle(acc);
    chk("width_mem_data", 64'(bus.mem_data_out), 64'hA5A5_5A5A);
    chk("width_reg_dest", 64'(bus.reg_dest_out), 64'd63);

    // async reset mid-cycle with a valid store held
    drive(1, 0, 0, mk(5'b00100, 32'hCAFE, 32'h9, 6'd9));
    cycle(acc);
    drive(0, 0, 0, idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_wm", 64'(bus.wm_out), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_alu_zero", 64'(bus.alu_result_out), 64'd0);
    q.delete();
    last = idle;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 15) == 0, rnd_item());
      cycle(acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
